instruction_dec: RTL and testbench
==================================

INSTRUCTION_DEC -- requirements
Module: instruction_dec

Interface
REQ-001 Parameter OPCODE_MAX, default 6: highest legal opcode value; opcodes above it are illegal.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  instr carries an instruction to decode this cycle.
REQ-005 instr  input  32  instruction word.
REQ-006 out_valid  output  1  decoded fields below correspond to a captured instruction.
REQ-007 opcode  output  4  major opcode field.
REQ-008 reg1  output  5  first register specifier.
REQ-009 reg2  output  5  second register specifier.
REQ-010 imm  output  16  immediate field, raw and not extended.
REQ-011 funcode  output  4  function code field.
REQ-012 illegal  output  1  captured opcode exceeds OPCODE_MAX; present only when ILLEGAL_CHECK_EN is defined.

Function
REQ-013 Field mapping SHALL be: opcode=instr[31:28], reg1=instr[27:23], reg2=instr[22:18], imm=instr[15:0], funcode=instr[3:0].
REQ-014 imm and funcode SHALL overlap intentionally; consumers select a field by opcode class.
REQ-015 Every output SHALL be registered, with latency exactly 1 cycle from the in_valid/instr sample to the output.
REQ-016 On a rising edge with in_valid=1, all field registers SHALL load from instr and out_valid SHALL be set to 1.
REQ-017 On a rising edge with in_valid=0, field registers SHALL hold their values and out_valid SHALL be set to 0.
REQ-018 Back-to-back in_valid=1 cycles SHALL each produce one decoded result, giving a throughput of one instruction per cycle with no stalls.
REQ-019 Decoding SHALL be purely bit extraction: no arithmetic, no sign extension, and no dependence on opcode value except the illegal flag.
REQ-020 X or Z bits on instr while in_valid=0 SHALL NOT propagate to the outputs.

Reset
REQ-021 While rst=1, out_valid, opcode, reg1, reg2, imm, funcode and illegal SHALL be 0 immediately, without waiting for clk.
REQ-022 An instruction presented in the same cycle that rst deasserts SHALL be captured on the next rising edge after deassertion.
REQ-023 Reset asserted mid-stream SHALL discard the in-flight result; out_valid SHALL stay 0 until a new in_valid=1 capture.

Configuration
REQ-024 Macro INSTRUCTION_DEC_ILLEGAL_CHECK_EN defined: the illegal port SHALL exist and be registered as (instr[31:28] > OPCODE_MAX) on each capture, held otherwise.
REQ-025 Macro undefined: the illegal port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-026 Package instruction_dec_pkg SHALL hold the field bit positions, the field widths, the OPCODE_MAX default and named opcode constants 0..6.
REQ-027 The field slicing SHALL be done in one combinational sub-module, instr_field_split, that is shared with other decode consumers; the registers SHALL live in instruction_dec.

Verification
REQ-028 instr=0x05555524, in_valid=1 -> next cycle: opcode=0, reg1=10, reg2=21, imm=0x5524, funcode=4, out_valid=1.
REQ-029 The same word with the top nibble stepped 1..6 on consecutive cycles -> opcode 1..6 on consecutive cycles, other fields unchanged, illegal=0.
REQ-030 instr=0xF0000000 with the macro defined -> illegal=1 and opcode=15; with the macro undefined, the build has no illegal port.
REQ-031 Capture 0x05555524, then in_valid=0 for 3 cycles -> fields held and out_valid=0.
REQ-032 rst pulsed between clock edges while out_valid=1 -> all outputs 0 before the next edge.
REQ-033 instr=0xFFFFFFFF -> reg1=31, reg2=31, imm=0xFFFF, funcode=15.

Source files
------------

// File: rtl/instruction_dec_pkg.sv
// rtl/instruction_dec_pkg.sv - field positions, widths and opcode constants for instruction_dec
package instruction_dec_pkg;

   localparam int INSTR_W   = 32;

   localparam int OPC_W     = 4;
   localparam int REG_W     = 5;
   localparam int IMM_W     = 16;
   localparam int FUNC_W    = 4;

   localparam int OPC_LSB   = 28;
   localparam int REG1_LSB  = 23;
   localparam int REG2_LSB  = 18;
   localparam int IMM_LSB   = 0;
   localparam int FUNC_LSB  = 0;

   localparam logic [OPC_W-1:0] OPCODE_MAX_DEFAULT = 4'd6;

   typedef enum logic [OPC_W-1:0] {
      OP_0 = 4'd0,
      OP_1 = 4'd1,
      OP_2 = 4'd2,
      OP_3 = 4'd3,
      OP_4 = 4'd4,
      OP_5 = 4'd5,
      OP_6 = 4'd6
   } opcode_e;

   // True when an opcode lies beyond the legal range.
   function automatic logic opcode_is_illegal(input logic [OPC_W-1:0] op,
                                              input logic [OPC_W-1:0] op_max);
      return op > op_max;
   endfunction

endpackage

// File: rtl/instr_field_split.sv
// rtl/instr_field_split.sv - combinational slicing of an instruction word into its fields
module instr_field_split
   import instruction_dec_pkg::*;
(
   input  logic [INSTR_W-1:0] instr,
   output logic [OPC_W-1:0]   opcode,
   output logic [REG_W-1:0]   reg1,
   output logic [REG_W-1:0]   reg2,
   output logic [IMM_W-1:0]   imm,
   output logic [FUNC_W-1:0]  funcode
);

   // Bits 17:16 carry no field; gathered here so they are visibly accounted for.
   logic unused_bits;
   assign unused_bits = ^instr[REG2_LSB-1:IMM_LSB+IMM_W];

   // imm and funcode overlap on purpose; the consumer picks one by opcode class.
   assign opcode  = instr[OPC_LSB  +: OPC_W];
   assign reg1    = instr[REG1_LSB +: REG_W];
   assign reg2    = instr[REG2_LSB +: REG_W];
   assign imm     = instr[IMM_LSB  +: IMM_W];
   assign funcode = instr[FUNC_LSB +: FUNC_W];

endmodule

// File: rtl/instruction_dec.sv
// rtl/instruction_dec.sv - registered instruction field decoder; INSTRUCTION_DEC_ILLEGAL_CHECK_EN adds the illegal flag
module instruction_dec
   import instruction_dec_pkg::*;
#(
   parameter logic [OPC_W-1:0] OPCODE_MAX = OPCODE_MAX_DEFAULT
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [INSTR_W-1:0] instr,
   output logic               out_valid,
   output logic [OPC_W-1:0]   opcode,
   output logic [REG_W-1:0]   reg1,
   output logic [REG_W-1:0]   reg2,
   output logic [IMM_W-1:0]   imm,
   output logic [FUNC_W-1:0]  funcode
`ifdef INSTRUCTION_DEC_ILLEGAL_CHECK_EN
   ,
   output logic               illegal
`endif
);

   logic [OPC_W-1:0]  f_opcode;
   logic [REG_W-1:0]  f_reg1;
   logic [REG_W-1:0]  f_reg2;
   logic [IMM_W-1:0]  f_imm;
   logic [FUNC_W-1:0] f_funcode;

   instr_field_split u_split (
      .instr   (instr),
      .opcode  (f_opcode),
      .reg1    (f_reg1),
      .reg2    (f_reg2),
      .imm     (f_imm),
      .funcode (f_funcode)
   );

   // Valid tracks in_valid every cycle; fields load only on a capture so idle X never reaches them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         opcode    <= '0;
         reg1      <= '0;
         reg2      <= '0;
         imm       <= '0;
         funcode   <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            opcode  <= f_opcode;
            reg1    <= f_reg1;
            reg2    <= f_reg2;
            imm     <= f_imm;
            funcode <= f_funcode;
         end
      end
   end

`ifdef INSTRUCTION_DEC_ILLEGAL_CHECK_EN
   // Illegal flag is captured alongside the fields and held between captures.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         illegal <= 1'b0;
      end else if (in_valid) begin
         illegal <= opcode_is_illegal(f_opcode, OPCODE_MAX);
      end
   end
`endif

endmodule

// File: tb/tb_instruction_dec.sv
// tb/tb_instruction_dec.sv - self-checking bench for instruction_dec against a behavioural model
module tb_instruction_dec;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] instr;
   logic        out_valid;
   logic [3:0]  opcode;
   logic [4:0]  reg1;
   logic [4:0]  reg2;
   logic [15:0] imm;
   logic [3:0]  funcode;
`ifdef INSTRUCTION_DEC_ILLEGAL_CHECK_EN
   logic        illegal;
`endif

   int checks;
   int fails;

   // model state
   logic        m_valid;
   logic [3:0]  m_op;
   logic [4:0]  m_r1;
   logic [4:0]  m_r2;
   logic [15:0] m_imm;
   logic [3:0]  m_fn;
   logic        m_ill;

   instruction_dec dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .instr     (instr),
      .out_valid (out_valid),
      .opcode    (opcode),
      .reg1      (reg1),
      .reg2      (reg2),
      .imm       (imm),
      .funcode   (funcode)
`ifdef INSTRUCTION_DEC_ILLEGAL_CHECK_EN
      ,
      .illegal   (illegal)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [34:0] obs();
      return {out_valid, opcode, reg1, reg2, imm, funcode};
   endfunction

   function automatic logic [34:0] expv();
      return {m_valid, m_op, m_r1, m_r2, m_imm, m_fn};
   endfunction

   task automatic model_reset();
      m_valid = 0; m_op = 0; m_r1 = 0; m_r2 = 0; m_imm = 0; m_fn = 0; m_ill = 0;
   endtask

   // Advance one clock edge, then update the model from what was presented before it.
   task automatic tick();
      logic        v;
      logic [31:0] w;
      longint unsigned u;
      v = in_valid;
      w = instr;
      @(posedge clk);
      #1;
      if (!rst) begin
         m_valid = v;
         if (v) begin
            u     = longint'(w);
            m_op  = 4'(u / (64'd1 << 28));
            m_r1  = 5'((u / (64'd1 << 23)) % 32);
            m_r2  = 5'((u / (64'd1 << 18)) % 32);
            m_imm = 16'(u % 65536);
            m_fn  = 4'(u % 16);
            m_ill = (u / (64'd1 << 28)) > 6;
         end
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (obs() !== 35'd0) begin
         fails++;
         $display("FAIL reset_async_zero: got %h want 0", obs());
      end
      tick(); tick();
      checks++;
      if (obs() !== 35'd0) begin
         fails++;
         $display("FAIL reset_held_zero: got %h want 0", obs());
      end
`ifdef INSTRUCTION_DEC_ILLEGAL_CHECK_EN
      checks++;
      if (illegal !== 1'b0) begin
         fails++;
         $display("FAIL reset_illegal: got %b want 0", illegal);
      end
`endif
      // instruction presented in the cycle reset deasserts is captured at the next edge
      rst = 0; in_valid = 1; instr = 32'h05555524;
      tick();
      checks++;
      if ({out_valid, opcode, reg1, reg2, imm, funcode} !== {1'b1, 4'd0, 5'd10, 5'd21, 16'h5524, 4'd4}) begin
         fails++;
         $display("FAIL known_vector_0x05555524: got %h want %h", obs(),
                  {1'b1, 4'd0, 5'd10, 5'd21, 16'h5524, 4'd4});
      end
   endtask

   task automatic test_opcode_step();
      for (int k = 1; k <= 6; k++) begin
         instr = {4'(k), 28'h5555524};
         in_valid = 1;
         tick();
         checks++;
         if ({out_valid, opcode, reg1, reg2, imm, funcode} !== {1'b1, 4'(k), 5'd10, 5'd21, 16'h5524, 4'd4}) begin
            fails++;
            $display("FAIL opcode_step_%0d: got %h want %h", k, obs(),
                     {1'b1, 4'(k), 5'd10, 5'd21, 16'h5524, 4'd4});
         end
`ifdef INSTRUCTION_DEC_ILLEGAL_CHECK_EN
         checks++;
         if (illegal !== 1'b0) begin
            fails++;
            $display("FAIL opcode_step_illegal_%0d: got %b want 0", k, illegal);
         end
`endif
      end
   endtask

   task automatic test_all_ones();
      in_valid = 1; instr = 32'hFFFFFFFF;
      tick();
      checks++;
      if ({out_valid, opcode, reg1, reg2, imm, funcode} !== {1'b1, 4'd15, 5'd31, 5'd31, 16'hFFFF, 4'd15}) begin
         fails++;
         $display("FAIL all_ones: got %h want %h", obs(),
                  {1'b1, 4'd15, 5'd31, 5'd31, 16'hFFFF, 4'd15});
      end
   endtask

   task automatic test_hold();
      in_valid = 1; instr = 32'h05555524;
      tick();
      in_valid = 0; instr = 32'hA5A5A5A5;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if ({out_valid, opcode, reg1, reg2, imm, funcode} !== {1'b0, 4'd0, 5'd10, 5'd21, 16'h5524, 4'd4}) begin
            fails++;
            $display("FAIL hold_cycle_%0d: got %h want %h", k, obs(),
                     {1'b0, 4'd0, 5'd10, 5'd21, 16'h5524, 4'd4});
         end
      end
   endtask

   task automatic test_idle_x();
      in_valid = 1; instr = 32'h3ABCDEF1;
      tick();
      in_valid = 0; instr = 'x;
      tick(); tick();
      checks++;
      if (obs() !== expv()) begin
         fails++;
         $display("FAIL idle_x_blocked: got %h want %h", obs(), expv());
      end
      instr = 32'h0;
   endtask

   task automatic test_async_reset();
      in_valid = 1; instr = 32'h6FEDCBA9;
      tick();
      in_valid = 0;
      #3;
      rst = 1;
      #1;
      model_reset();
      checks++;
      if (obs() !== 35'd0) begin
         fails++;
         $display("FAIL midcycle_reset: got %h want 0", obs());
      end
`ifdef INSTRUCTION_DEC_ILLEGAL_CHECK_EN
      checks++;
      if (illegal !== 1'b0) begin
         fails++;
         $display("FAIL midcycle_reset_illegal: got %b want 0", illegal);
      end
`endif
      tick();
      rst = 0;
      tick(); tick();
      checks++;
      if (obs() !== 35'd0) begin
         fails++;
         $display("FAIL post_reset_idle: got %h want 0", obs());
      end
   endtask

`ifdef INSTRUCTION_DEC_ILLEGAL_CHECK_EN
   task automatic test_illegal();
      in_valid = 1; instr = 32'hF0000000;
      tick();
      checks++;
      if ({illegal, opcode} !== {1'b1, 4'd15}) begin
         fails++;
         $display("FAIL illegal_0xF: got %b/%0d want 1/15", illegal, opcode);
      end
      instr = 32'h70000000;
      tick();
      checks++;
      if (illegal !== 1'b1) begin
         fails++;
         $display("FAIL illegal_boundary_7: got %b want 1", illegal);
      end
      in_valid = 0;
      tick();
      checks++;
      if (illegal !== 1'b1) begin
         fails++;
         $display("FAIL illegal_held: got %b want 1", illegal);
      end
   endtask
`endif

   task automatic test_back_to_back_random();
      for (int k = 0; k < 400; k++) begin
         in_valid = ($urandom % 4) != 0;
         instr = $urandom;
         tick();
         checks++;
         if (obs() !== expv()) begin
            fails++;
            $display("FAIL random_cycle_%0d: got %h want %h", k, obs(), expv());
         end
`ifdef INSTRUCTION_DEC_ILLEGAL_CHECK_EN
         checks++;
         if (illegal !== m_ill) begin
            fails++;
            $display("FAIL random_illegal_%0d: got %b want %b", k, illegal, m_ill);
         end
`endif
      end
      in_valid = 0;
   endtask

   initial begin
      checks = 0;
      fails = 0;
      rst = 1;
      in_valid = 0;
      instr = 32'h0;
      model_reset();
      test_reset();
      test_opcode_step();
      test_all_ones();
      test_hold();
      test_idle_x();
      test_async_reset();
`ifdef INSTRUCTION_DEC_ILLEGAL_CHECK_EN
      test_illegal();
`endif
      test_back_to_back_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
